bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly upstream of the BCD-to-seven-segment decoder. It converts a binary count or measurement into packed BCD digits, and each 4-bit digit of the result feeds one decoder instance. A start/busy/done handshake lets a controller request a conversion and know when the digits are valid.

## Interface
- WIDTH, 8: width of the binary input; also the number of shift iterations per conversion.
- DIGITS, 3: number of BCD digits produced; bcd_out is 4*DIGITS bits wide.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears all state immediately, independent of clk.
- start  input  1  conversion request; sampled only while idle.
- bin_in  input  WIDTH  unsigned binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd_out has just been updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0], digit k in bits [4k+3:4k]; registered and held between conversions.
- overflow  output  1  result did not fit in DIGITS digits; registered alongside bcd_out.

## Operation
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
- Internal state:
  - bin_sr (WIDTH bits): binary shift register.
  - bcd_sr (4*DIGITS bits): BCD scratch register.
  - cnt: iteration counter, range 0..WIDTH-1.
  - ovf_acc: sticky overflow accumulator.
- IDLE with start=1 at a rising edge:
  - bin_sr <= bin_in, bcd_sr <= 0, cnt <= 0, ovf_acc <= 0.
  - Go to SHIFT.
- IDLE with start=0: no change.
- SHIFT, each edge, in this order:
  - Correction: every digit of bcd_sr that is >= 5 gets +3. Digit add is 4-bit with no inter-digit carry; a digit of at most 9 plus 3 never exceeds 12, so no wrap.
  - Shift: the corrected {bcd_sr, bin_sr} shifts left by one. The MSB of bin_sr enters bit 0 of bcd_sr, and 0 enters bit 0 of bin_sr.
  - Overflow capture: the bit shifted out of the top of bcd_sr is ORed into ovf_acc.
  - Counter: cnt increments.
- SHIFT when cnt == WIDTH-1:
  - The shift above completes, and the post-shift bcd_sr is written to bcd_out.
  - overflow <= ovf_acc OR the bit shifted out on this edge.
  - done <= 1. State goes to IDLE.
- start is ignored while in SHIFT. bin_in changes have no effect after capture.
- done is high for exactly one cycle. On every other edge done <= 0.
- bcd_out and overflow change only on a completion edge, so the downstream decoder sees stable digits between conversions.
- When overflow=1, bcd_out holds the value mod 10^DIGITS; the low digits remain correct.
- Reset (rst_n=0, at any time including mid-conversion):
  - State goes to IDLE. busy=0, done=0, bcd_out=0, overflow=0.
  - bin_sr, bcd_sr, cnt and ovf_acc are cleared.
  - Any in-flight conversion is discarded; no done is produced for it.
  - After rst_n deasserts, the first rising edge with start=1 begins a fresh conversion.

## Timing
- Acceptance edge E0: start=1 sampled in IDLE. From E0, busy=1.
- Iteration edges E1..E_WIDTH perform the WIDTH iterations.
- At E_WIDTH: bcd_out and overflow update, done=1, busy=0.
- Latency: WIDTH cycles from the acceptance edge to done/bcd_out valid (8 for defaults). The converter is occupied for WIDTH+1 edges per conversion.
- Back-to-back: start=1 in the cycle where done=1 is accepted at E_WIDTH+1, since the state is IDLE. Sustained throughput is one conversion per WIDTH+1 cycles.
- Legal parameter ranges: WIDTH >= 1, DIGITS >= 1. Counter width is $clog2(WIDTH), with a minimum of 1.

## Test plan
- Conversion of 255 (defaults): bin_in=8'd255, start pulse -> busy=1 for 8 cycles, then done pulse, bcd_out=12'h255, overflow=0.
- Zero and small values: bin_in=0 -> bcd_out=12'h000. bin_in=9 -> 12'h009. bin_in=99 -> 12'h099. bin_in=100 -> 12'h100. Each has done exactly 8 cycles after acceptance.
- Start while busy: start=1 with bin_in=42, then start=1 with bin_in=7 at cycle 3 of busy -> second request ignored, bcd_out=12'h042, single done pulse.
- Back-to-back: 128 accepted, then start=1 with bin_in=37 held during the done cycle -> bcd_out=12'h128, then 9 cycles later bcd_out=12'h037. bcd_out holds 12'h128 in between.
- Reset mid-conversion: rst_n=0 asynchronously at cycle 4 of converting 200 -> busy, done, bcd_out and overflow are 0 immediately. No done follows. A subsequent start with 200 yields 12'h200.
- Overflow (DIGITS=2, WIDTH=8): bin_in=200 -> bcd_out=8'h00, overflow=1. bin_in=99 -> bcd_out=8'h99, overflow=0.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t              state;
  logic [WIDTH-1:0]    bin_sr, bin_nx;
  logic [4*DIGITS-1:0] bcd_sr, bcd_nx, corr;
  logic [CW-1:0]       cnt;
  logic                ovf_acc, shout;
  always_comb begin
    corr = bcd_sr;
    for (int k = 0; k < DIGITS; k++)
      corr[4*k+:4] = (bcd_sr[4*k+:4] >= 4'd5) ? bcd_sr[4*k+:4] + 4'd3 : bcd_sr[4*k+:4];
    {shout, bcd_nx, bin_nx} = {corr, bin_sr, 1'b0};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          bin_sr  <= bin_in;
          bcd_sr  <= '0;
          cnt     <= '0;
          ovf_acc <= 1'b0;
          state   <= SHIFT;
          busy    <= 1'b1;
        end
      end else begin
        bin_sr  <= bin_nx;
        bcd_sr  <= bcd_nx;
        cnt     <= cnt + CW'(1);
        ovf_acc <= ovf_acc | shout;
        if (cnt == CW'(WIDTH-1)) begin
          bcd_out  <= bcd_nx;
          overflow <= ovf_acc | shout;
          done     <= 1'b1;
          state    <= IDLE;
          busy     <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for the default 3-digit converter and a 2-digit overflow variant
module tb_bin_to_bcd_seq;
  localparam int W = 8;
  typedef struct packed {logic [11:0] bcd; logic ovf;} exp_t;
  logic clk = 0, rst_n = 1, start = 0, start2 = 0;
  logic [7:0] bin_in = 0, bin2 = 0;
  logic busy, done, overflow, busy2, done2, overflow2;
  logic [11:0] bcd_out;
  logic [7:0] bcd2;
  exp_t q[$], q2[$];
  exp_t e1, e2;
  int checks = 0, errors = 0, bcnt = 0, bcnt2 = 0;
  logic [11:0] held = 0;
  logic [7:0] held2 = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(overflow2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) bcnt++;
      if (done) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e1 = q.pop_front();
          chk("bcd_out", bcd_out, e1.bcd);
          chk("overflow", overflow, e1.ovf);
          chk("latency", bcnt, W);
          held = e1.bcd;
        end
        bcnt = 0;
      end else chk("bcd_hold", bcd_out, held);
    end else begin
      bcnt = 0;
      held = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy2) bcnt2++;
      if (done2) begin
        if (q2.size() == 0) chk("spurious_done2", 1, 0);
        else begin
          e2 = q2.pop_front();
          chk("bcd_out2", bcd2, e2.bcd[7:0]);
          chk("overflow2", overflow2, e2.ovf);
          chk("latency2", bcnt2, W);
          held2 = e2.bcd[7:0];
        end
        bcnt2 = 0;
      end else chk("bcd_hold2", bcd2, held2);
    end else begin
      bcnt2 = 0;
      held2 = 0;
    end
  end

  // ends in the done cycle of the conversion it issued
  task automatic conv(input logic [7:0] v, input logic [11:0] eb, input logic eo);
    start = 1; bin_in = v;
    q.push_back('{eb, eo});
    @(posedge clk); #1 start = 0; bin_in = 8'($urandom);
    repeat (W) @(posedge clk);
    #1;
  endtask

  task automatic conv2(input logic [7:0] v, input logic [7:0] eb, input logic eo);
    start2 = 1; bin2 = v;
    q2.push_back('{{4'h0, eb}, eo});
    @(posedge clk); #1 start2 = 0; bin2 = 8'($urandom);
    repeat (W) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bcd2", bcd2, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle(1);
    conv(8'd255, 12'h255, 0);
    conv(8'd0,   12'h000, 0);
    conv(8'd9,   12'h009, 0);
    conv(8'd99,  12'h099, 0);
    conv(8'd100, 12'h100, 0);
    idle(2);
    // a second request arriving mid-conversion must be dropped
    start = 1; bin_in = 8'd42;
    q.push_back('{12'h042, 1'b0});
    @(posedge clk); #1 start = 0;
    idle(2);
    start = 1; bin_in = 8'd7;
    @(posedge clk); #1 start = 0;
    idle(4);
    idle(4);
    conv(8'd128, 12'h128, 0);
    conv(8'd37,  12'h037, 0);
    idle(2);
    start = 1; bin_in = 8'd200;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_bcd", bcd_out, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(posedge clk); #1 rst_n = 1;
    idle(12);
    conv(8'd200, 12'h200, 0);
    idle(2);
    conv2(8'd200, 8'h00, 1);
    conv2(8'd99,  8'h99, 0);
    conv2(8'd255, 8'h55, 1);
    idle(12);
    chk("pending_q", q.size(), 0);
    chk("pending_q2", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
